// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MiniMIPS register file constants and requester indices
package mips_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 8;

    // Writeback requester identities; also the encoding of the round-robin pointer
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

endpackage

// File: rtl/mips_age_counter.sv
// rtl/mips_age_counter.sv - saturating per-requester wait counter with clear
module mips_age_counter #(
    parameter int AGE_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [AGE_W-1:0] o_age,
    output logic             o_sat_next
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_next;

    // Clear wins over increment; increment stops at the all-ones value
    always_comb begin
        w_age_next = r_age;
        if (i_clr) begin
            w_age_next = '0;
        end else if (i_inc && (r_age != AGE_MAX)) begin
            w_age_next = r_age + 1'b1;
        end
    end

    // Counter state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_age <= '0;
        end else begin
            r_age <= w_age_next;
        end
    end

    assign o_age      = r_age;
    assign o_sat_next = (w_age_next == AGE_MAX);

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// rtl/mips_regfile_write_arbiter.sv - age/round-robin arbiter for the register file write port
module mips_regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int AGE_W        = 4,
    parameter int ZERO_PROTECT = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req0,
    input  logic [ADDR_W-1:0]        i_reg0,
    input  logic [DATA_W-1:0]        i_data0,
    output logic                     o_gnt0,
    input  logic                     i_req1,
    input  logic [ADDR_W-1:0]        i_reg1,
    input  logic [DATA_W-1:0]        i_data1,
    output logic                     o_gnt1,
    input  logic                     i_stall,
    output logic [ADDR_W-1:0]        o_write_reg,
    output logic [DATA_W-1:0]        o_write_data,
    output logic                     o_signal_reg_write,
    output logic [(1<<ADDR_W)-1:0]   o_busy_mask,
    output logic                     o_starve
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [NREG-1:0] ONE_BIT = {{(NREG-1){1'b0}}, 1'b1};

    logic [AGE_W-1:0]  w_age0;
    logic [AGE_W-1:0]  w_age1;
    logic              w_sat_next0;
    logic              w_sat_next1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_will_write;
    logic [ADDR_W-1:0] w_win_reg;
    logic [DATA_W-1:0] w_win_data;
    logic [NREG-1:0]   w_busy_next;

    req_idx_e          r_rr_ptr;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_signal_reg_write;
    logic [NREG-1:0]   r_busy_mask;
    logic              r_starve;

    mips_age_counter #(.AGE_W(AGE_W)) u_age0 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (i_req0 & ~w_gnt0),
        .i_clr      (~i_req0 | w_gnt0),
        .o_age      (w_age0),
        .o_sat_next (w_sat_next0)
    );

    mips_age_counter #(.AGE_W(AGE_W)) u_age1 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (i_req1 & ~w_gnt1),
        .i_clr      (~i_req1 | w_gnt1),
        .o_age      (w_age1),
        .o_sat_next (w_sat_next1)
    );

    // Grant: lone requester wins; on contention the older wins, ties go to rr_ptr
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst && !i_stall) begin
            if (i_req0 && i_req1) begin
                if (w_age0 > w_age1) begin
                    w_gnt0 = 1'b1;
                end else if (w_age1 > w_age0) begin
                    w_gnt1 = 1'b1;
                end else if (r_rr_ptr == REQ_ALU) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1;
            end
        end
    end

    assign w_any_gnt    = w_gnt0 | w_gnt1;
    assign w_win_reg    = w_gnt1 ? i_reg1 : i_reg0;
    assign w_win_data   = w_gnt1 ? i_data1 : i_data0;
    assign w_will_write = w_any_gnt && !((ZERO_PROTECT != 0) && (w_win_reg == '0));

    // Pending mask: every held-but-unserved target plus the write about to issue
    always_comb begin
        w_busy_next = '0;
        if (i_req0 && !w_gnt0) begin
            w_busy_next = w_busy_next | (ONE_BIT << i_reg0);
        end
        if (i_req1 && !w_gnt1) begin
            w_busy_next = w_busy_next | (ONE_BIT << i_reg1);
        end
        if (w_will_write) begin
            w_busy_next = w_busy_next | (ONE_BIT << w_win_reg);
        end
    end

    // Round-robin pointer moves to the loser only when both actually competed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= REQ_ALU;
        end else if (i_req0 && i_req1 && w_any_gnt) begin
            r_rr_ptr <= w_gnt0 ? REQ_MEM : REQ_ALU;
        end
    end

    // Write stage: capture the winner; address/data hold when nothing is granted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write_reg        <= '0;
            r_write_data       <= '0;
            r_signal_reg_write <= 1'b0;
        end else if (w_any_gnt) begin
            r_write_reg        <= w_win_reg;
            r_write_data       <= w_win_data;
            r_signal_reg_write <= w_will_write;
        end else begin
            r_signal_reg_write <= 1'b0;
        end
    end

    // Hazard mask and starvation flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy_mask <= '0;
            r_starve    <= 1'b0;
        end else begin
            r_busy_mask <= w_busy_next;
            r_starve    <= w_sat_next0 | w_sat_next1;
        end
    end

    assign o_gnt0             = w_gnt0;
    assign o_gnt1             = w_gnt1;
    assign o_write_reg        = r_write_reg;
    assign o_write_data       = r_write_data;
    assign o_signal_reg_write = r_signal_reg_write;
    assign o_busy_mask        = r_busy_mask;
    assign o_starve           = r_starve;

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// tb/tb_mips_regfile_write_arbiter.sv - scoreboard bench for the register file write arbiter
module tb_mips_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, stall;
    logic [2:0]  reg0, reg1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1;
    logic [2:0]  write_reg;
    logic [31:0] write_data;
    logic        swe;
    logic [7:0]  busy_mask;
    logic        starve;

    int n_checks = 0;
    int n_fail   = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;

    always #5 clk = ~clk;

    mips_regfile_write_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (3),
        .AGE_W        (4),
        .ZERO_PROTECT (1)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req0             (req0),
        .i_reg0             (reg0),
        .i_data0            (data0),
        .o_gnt0             (gnt0),
        .i_req1             (req1),
        .i_reg1             (reg1),
        .i_data1            (data1),
        .o_gnt1             (gnt1),
        .i_stall            (stall),
        .o_write_reg        (write_reg),
        .o_write_data       (write_data),
        .o_signal_reg_write (swe),
        .o_busy_mask        (busy_mask),
        .o_starve           (starve)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expw(input logic [2:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic step(input string name, input logic eg0, input logic eg1);
        @(negedge clk);
        chk({name, "_gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
        chk({name, "_gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
        reg0 = '0; reg1 = '0; data0 = '0; data1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b0 && swe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_write_reg", {29'd0, write_reg}, {29'd0, mon_e[34:32]});
                chk("mon_write_data", write_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_swe", {31'd0, swe}, 32'd0);
        chk("rst_busy", {24'd0, busy_mask}, 32'd0);
        chk("rst_starve", {31'd0, starve}, 32'd0);
        rst = 1'b0;

        // Reset asserted mid-stream
        req1 = 1'b1; reg1 = 3'd6; data1 = 32'h66;
        step("s1_a", 1'b0, 1'b1); expw(3'd6, 32'h66); adv();
        req1 = 1'b0; req0 = 1'b1; reg0 = 3'd3; data0 = 32'h33; stall = 1'b1;
        step("s1_b", 1'b0, 1'b0); adv();
        step("s1_c", 1'b0, 1'b0);
        chk("s1_busy_held", {24'd0, busy_mask}, 32'h08);
        chk("s1_wreg_hold", {29'd0, write_reg}, 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("s1_rst_wreg", {29'd0, write_reg}, 32'd0);
        chk("s1_rst_wdata", write_data, 32'd0);
        chk("s1_rst_swe", {31'd0, swe}, 32'd0);
        chk("s1_rst_busy", {24'd0, busy_mask}, 32'd0);
        chk("s1_rst_gnt0", {31'd0, gnt0}, 32'd0);
        adv();
        rst = 1'b0; stall = 1'b0;
        step("s1_d", 1'b1, 1'b0); expw(3'd3, 32'h33); adv();
        req0 = 1'b0;
        step("s1_e", 1'b0, 1'b0);
        chk("s1_swe_after", {31'd0, swe}, 32'd1);
        adv();

        // Single requester
        req1 = 1'b1; reg1 = 3'd5; data1 = 32'h0000_00AA;
        step("s2_a", 1'b0, 1'b1); expw(3'd5, 32'hAA); adv();
        req1 = 1'b0;
        step("s2_b", 1'b0, 1'b0);
        chk("s2_busy", {24'd0, busy_mask}, 32'h20);
        chk("s2_swe", {31'd0, swe}, 32'd1);
        adv();
        step("s2_c", 1'b0, 1'b0);
        chk("s2_swe_drop", {31'd0, swe}, 32'd0);
        adv();

        // Tie and round-robin
        do_reset();
        req0 = 1'b1; reg0 = 3'd1; data0 = 32'h101;
        req1 = 1'b1; reg1 = 3'd2; data1 = 32'h202;
        step("s3_c0", 1'b1, 1'b0); expw(3'd1, 32'h101); adv();
        reg0 = 3'd3; data0 = 32'h303;
        step("s3_c1", 1'b0, 1'b1); expw(3'd2, 32'h202); adv();
        req0 = 1'b0; req1 = 1'b0;
        step("s3_idle1", 1'b0, 1'b0);
        chk("s3_busy_a", {24'd0, busy_mask}, 32'h0C);
        adv();
        req0 = 1'b1; reg0 = 3'd4; data0 = 32'h404;
        req1 = 1'b1; reg1 = 3'd5; data1 = 32'h505;
        step("s3_tie_a", 1'b1, 1'b0); expw(3'd4, 32'h404); adv();
        req0 = 1'b0; req1 = 1'b0;
        step("s3_idle2", 1'b0, 1'b0);
        chk("s3_busy_b", {24'd0, busy_mask}, 32'h30);
        adv();
        req0 = 1'b1; reg0 = 3'd6; data0 = 32'h606;
        req1 = 1'b1; reg1 = 3'd7; data1 = 32'h707;
        step("s3_tie_b", 1'b0, 1'b1); expw(3'd7, 32'h707); adv();
        req1 = 1'b0;
        step("s3_tail", 1'b1, 1'b0); expw(3'd6, 32'h606); adv();
        req0 = 1'b0;
        step("s3_idle3", 1'b0, 1'b0); adv();

        // Starvation under stall
        do_reset();
        stall = 1'b1;
        req0 = 1'b1; reg0 = 3'd4; data0 = 32'h44;
        req1 = 1'b1; reg1 = 3'd5; data1 = 32'h55;
        for (int i = 0; i < 16; i++) begin
            step("s4_stall", 1'b0, 1'b0);
            if (i == 14) chk("s4_starve_pre", {31'd0, starve}, 32'd0);
            if (i == 15) begin
                chk("s4_starve_set", {31'd0, starve}, 32'd1);
                chk("s4_busy", {24'd0, busy_mask}, 32'h30);
            end
            adv();
        end
        stall = 1'b0;
        step("s4_rel", 1'b1, 1'b0); expw(3'd4, 32'h44); adv();
        req0 = 1'b0;
        step("s4_next", 1'b0, 1'b1);
        chk("s4_starve_hold", {31'd0, starve}, 32'd1);
        expw(3'd5, 32'h55); adv();
        req1 = 1'b0;
        step("s4_done", 1'b0, 1'b0);
        chk("s4_starve_clr", {31'd0, starve}, 32'd0);
        adv();

        // Zero protect
        req0 = 1'b1; reg0 = 3'd0; data0 = 32'hFFFF_FFFF;
        step("s5_a", 1'b1, 1'b0); adv();
        req0 = 1'b0;
        step("s5_b", 1'b0, 1'b0);
        chk("s5_swe", {31'd0, swe}, 32'd0);
        chk("s5_busy", {24'd0, busy_mask}, 32'd0);
        adv();

        // Abandoned request
        do_reset();
        req1 = 1'b1; reg1 = 3'd2; data1 = 32'h222; stall = 1'b1;
        step("s6_a", 1'b0, 1'b0); adv();
        step("s6_b", 1'b0, 1'b0);
        chk("s6_busy_a", {24'd0, busy_mask}, 32'h04);
        adv();
        req1 = 1'b0; stall = 1'b0;
        step("s6_c", 1'b0, 1'b0); adv();
        step("s6_d", 1'b0, 1'b0);
        chk("s6_busy_clr", {24'd0, busy_mask}, 32'd0);
        chk("s6_swe", {31'd0, swe}, 32'd0);
        adv();
        req0 = 1'b1; reg0 = 3'd3; data0 = 32'h333;
        req1 = 1'b1; reg1 = 3'd2; data1 = 32'h222;
        step("s6_tie", 1'b1, 1'b0); expw(3'd3, 32'h333); adv();
        req0 = 1'b0;
        step("s6_e", 1'b0, 1'b1); expw(3'd2, 32'h222); adv();
        req1 = 1'b0;
        step("s6_f", 1'b0, 1'b0); adv();

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_regfile_write_arbiter.md
Name: mips_regfile_write_arbiter

Overview:
- Shares the single write port of the 8x32 MiniMIPS register file between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load).
- Arbitrates by age, with a round-robin tie-break.
- Registers the winning write into one output stage that drives the register file write_reg / write_data / signal_reg_write inputs.
- Exports a registered pending-write mask for hazard detection in decode.

Parameters:
- DATA_W, 32: write data width.
- ADDR_W, 3: register index width (8 registers).
- AGE_W, 4: width of the per-requester wait counters (saturating).
- ZERO_PROTECT, 0: when 1, writes to register 0 are granted but produce no write strobe.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req0  in  1  requester 0 write request.
- reg0  in  ADDR_W  requester 0 target register.
- data0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 accepted this cycle (combinational).
- req1  in  1  requester 1 write request.
- reg1  in  ADDR_W  requester 1 target register.
- data1  in  DATA_W  requester 1 write data.
- gnt1  out  1  requester 1 accepted this cycle (combinational).
- stall  in  1  blocks all grants while high.
- write_reg  out  ADDR_W  register file write address (registered).
- write_data  out  DATA_W  register file write data (registered).
- signal_reg_write  out  1  register file write enable (registered).
- busy_mask  out  2**ADDR_W  one bit per register with a pending or in-flight write (registered).
- starve  out  1  registered; high while any age counter is saturated.

Behaviour:
- Reset (asynchronous, rst=1):
  - write_reg, write_data, signal_reg_write, busy_mask and starve all clear to 0.
  - age0, age1 and rr_ptr clear to 0; rr_ptr=0 means requester 0 is preferred.
  - gnt0 and gnt1 are forced to 0.
  - Requests held across reset are re-arbitrated from the first edge after deassertion; nothing is replayed.
- Handshake:
  - A requester holds req, reg and data stable until it sees gnt high in the same cycle.
  - The transfer completes at that rising edge.
  - Dropping req without a grant abandons the request; this is legal.
- Grant logic (combinational, only when stall=0):
  - Only one req high: that requester is granted.
  - Both high, age0 != age1: the larger age wins.
  - Both high, ages equal: the requester selected by rr_ptr wins.
  - At most one gnt is high per cycle.
  - stall=1 or rst=1: no grants.
- rr_ptr: updates only on a cycle where both requesters competed and one was granted; it then points to the loser. Otherwise it holds.
- Age counters (per requester i):
  - req_i=1 and gnt_i=0: age_i increments, saturating at 2**AGE_W-1.
  - gnt_i=1 or req_i=0: age_i clears to 0.
- starve: registered as (next age0 saturated) OR (next age1 saturated).
- Write stage, one-cycle latency from grant:
  - On the edge ending a grant cycle, write_reg and write_data load the winner's reg and data.
  - signal_reg_write loads 1, except it loads 0 when ZERO_PROTECT=1 and the target register is 0.
  - In any cycle without a grant, signal_reg_write loads 0 and write_reg / write_data hold.
- busy_mask (registered), next value is the OR of:
  - onehot(reg_i) for each requester with req_i=1 and gnt_i=0;
  - onehot of the granted target register when the write stage will assert signal_reg_write next cycle.
- Simultaneous same-register requests: arbitration proceeds normally. The loser writes in a later cycle, so the last write wins. Ordering between the two requesters is the requesters' responsibility; the arbiter reports it via busy_mask only.
- stall:
  - Ages continue to count while stall is high.
  - signal_reg_write drops at the next edge.
  - busy_mask reflects all held requests.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W = 3, REG_DATA_W = 32, NUM_REGS = 8;
  - a requester-index enum: REQ_ALU = 0, REQ_MEM = 1.
- One sub-module: mips_age_counter, a saturating wait counter with clear; instantiated twice.
- Grant logic and the write stage stay inline in the top module.

Test Plan:
- Reset check: rst high mid-stream with req0=1, reg0=3 -> all outputs 0 immediately. After release: gnt0=1 in the first cycle, then write_reg=3, signal_reg_write=1 one cycle later.
- Single requester: req1=1, reg1=5, data1=32'h0000_00AA -> gnt1=1 in the same cycle. Next cycle write_reg=5, write_data=32'hAA, signal_reg_write=1 for exactly one cycle. busy_mask=8'b0010_0000 in that cycle.
- Tie and round-robin: both request from reset with equal ages:
  - cycle 0: gnt0;
  - cycle 1: gnt1 (age1=1 beats age0=0);
  - re-request both with equal ages: gnt0 or gnt1 alternates per rr_ptr.
  - Check signal_reg_write / write_reg sequence matches the grant order.
- Age priority and starvation: stall=1 for 16 cycles with req0=1, req1=1 -> no grants. Both ages saturate at 15 and starve=1. Release stall -> tie resolved by rr_ptr=0, so gnt0. Next cycle gnt1.
- Zero protect (ZERO_PROTECT=1): req0=1, reg0=0, data0=32'hFFFF_FFFF -> gnt0=1, signal_reg_write stays 0, register file register 0 unchanged.
- Abandoned request: req1=1, reg1=2 under stall for 2 cycles, then req1=0 -> busy_mask bit 2 clears on the next edge, age1=0, no write issued.
